// File: rtl/serial_tx_piso.sv
// Parallel-in serial-out frame transmitter: start bit 0, DATA_W data bits LSB first, stop bit 1.
// Each bit lasts CLK_DIV clocks; all outputs are registered and accept only when ready=1.
module serial_tx_piso #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic [DATA_W-1:0] din,
  input  logic              load,
  output logic              ready,
  output logic              busy,
  output logic              sout,
  output logic              done
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BW-1:0]     bitcnt_q, bitcnt_d;
  logic [DW-1:0]     divcnt_q, divcnt_d;
  logic              sout_d, ready_d, busy_d, done_d;
  logic              bit_end;

  assign bit_end = (divcnt_q == DIV_LAST);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      divcnt_q <= '0;
      sout     <= 1'b1;
      ready    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      divcnt_q <= divcnt_d;
      sout     <= sout_d;
      ready    <= ready_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    divcnt_d = divcnt_q + DIV_ONE;
    sout_d   = sout;
    ready_d  = ready;
    busy_d   = busy;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        divcnt_d = '0;
        sout_d   = 1'b1;
        ready_d  = 1'b1;
        busy_d   = 1'b0;
        if (load && ready) begin
          shreg_d = din;
          state_d = START;
          sout_d  = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d  = DATA;
          divcnt_d = '0;
          bitcnt_d = '0;
          sout_d   = shreg_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          divcnt_d = '0;
          if (bitcnt_q == BIT_LAST) begin
            state_d = STOP;
            sout_d  = 1'b1;
          end else begin
            // sout is registered, so it must present the post-shift LSB
            shreg_d  = shreg_q >> 1;
            bitcnt_d = bitcnt_q + BIT_ONE;
            sout_d   = shreg_d[0];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d  = IDLE;
          divcnt_d = '0;
          done_d   = 1'b1;
          ready_d  = 1'b1;
          busy_d   = 1'b0;
          sout_d   = 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        divcnt_d = '0;
      end
    endcase
  end

endmodule
